// File: rtl/rr_arb_pkg.sv
// Shared definitions for the four-requester round-robin grant arbiter.
//   NREQ    : number of requesters (fixed at 4)
//   IDX_W   : width of the binary grant index
//   state_e : arbiter FSM state, 1-bit encoding
//   rr_pick : reference winner selection for a request vector and last owner
package rr_arb_pkg;

  localparam int NREQ  = 4;
  localparam int IDX_W = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  // Winner = first set request searching upward from last_idx+1 with wrap.
  // Iterating from the farthest offset down lets the nearest one overwrite.
  // Returns last_idx when no request is set; callers qualify with |req.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NREQ-1:0]  req,
                                               input logic [IDX_W-1:0] last_idx);
    logic [IDX_W-1:0] idx;
    rr_pick = last_idx;
    for (int k = NREQ; k >= 1; k--) begin
      idx = last_idx + IDX_W'(k);
      if (req[idx]) rr_pick = idx;
    end
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational rotating-priority picker.
//   req_i      : request vector
//   last_idx_i : index of the previous grant owner
//   win_idx_o  : index of the winning requester (valid when any_o)
//   any_o      : at least one request is set
// Requests are rotated so that last_idx+1 lands on bit 0, a fixed
// lowest-bit-wins priority is applied, and the position is rotated back.
module rr_priority_pick #(
  parameter int NREQ  = 4,
  parameter int IDX_W = 2
) (
  input  logic [NREQ-1:0]  req_i,
  input  logic [IDX_W-1:0] last_idx_i,
  output logic [IDX_W-1:0] win_idx_o,
  output logic             any_o
);

  logic [IDX_W-1:0]  start;
  logic [2*NREQ-1:0] dbl;
  logic [NREQ-1:0]   rot;
  logic [IDX_W-1:0]  pos;

  assign start = last_idx_i + IDX_W'(1);
  assign dbl   = {req_i, req_i};
  assign rot   = dbl[start +: NREQ];

  always_comb begin
    pos = '0;
    for (int j = NREQ - 1; j >= 0; j--) begin
      if (rot[j]) pos = IDX_W'(j);
    end
  end

  // Rotate back; IDX_W-bit addition wraps modulo NREQ.
  assign win_idx_o = start + pos;
  assign any_o     = |req_i;

endmodule

// File: rtl/rr_grant_arbiter.sv
// Four-requester round-robin arbiter with held grant and one bubble cycle
// between grants.
//   clk       : system clock, rising edge
//   rst_n     : asynchronous active-low reset
//   req       : level-sensitive request lines
//   done      : current owner finishes; only looked at in GRANT
//   gnt       : registered one-hot grant, zero when idle
//   gnt_valid : gnt is non-zero
//   gnt_idx   : binary index of the granted requester; holds when idle
//   busy      : FSM is in GRANT
module rr_grant_arbiter #(
  parameter int NREQ  = 4,
  parameter int IDX_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NREQ-1:0]  req,
  input  logic             done,
  output logic [NREQ-1:0]  gnt,
  output logic             gnt_valid,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             busy
);

  import rr_arb_pkg::*;

  if (NREQ != 4 || IDX_W != 2) begin : g_bad_cfg
    $error("rr_grant_arbiter supports only NREQ=4, IDX_W=2");
  end

  state_e           state_q;
  logic [NREQ-1:0]  gnt_q;
  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] last_q;

  logic [IDX_W-1:0] win_idx_d;
  logic             any_req;
  logic [NREQ-1:0]  win_onehot_d;
  logic             release_d;

  rr_priority_pick #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req_i      (req),
    .last_idx_i (last_q),
    .win_idx_o  (win_idx_d),
    .any_o      (any_req)
  );

  assign win_onehot_d = {{(NREQ-1){1'b0}}, 1'b1} << win_idx_d;
  // done and a dropped owner request collapse into one release.
  assign release_d    = done || !req[idx_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      idx_q   <= '0;
      last_q  <= IDX_W'(NREQ - 1);  // requester 0 first after reset
    end else begin
      case (state_q)
        IDLE: begin
          if (any_req) begin
            gnt_q   <= win_onehot_d;
            idx_q   <= win_idx_d;
            state_q <= GRANT;
          end
        end
        GRANT: begin
          // No preemption: only the owner's done/drop matters here.
          if (release_d) begin
            gnt_q   <= '0;
            last_q  <= idx_q;
            state_q <= IDLE;
          end
        end
        default: begin
          gnt_q   <= '0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign gnt       = gnt_q;
  assign gnt_valid = |gnt_q;
  assign gnt_idx   = idx_q;
  assign busy      = (state_q == GRANT);

endmodule

// File: tb/tb_rr_grant_arbiter.sv
module tb_rr_grant_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic       done;
  logic [3:0] gnt;
  logic       gnt_valid;
  logic [1:0] gnt_idx;
  logic       busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rr_grant_arbiter #(.NREQ(4), .IDX_W(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .done      (done),
    .gnt       (gnt),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx),
    .busy      (busy)
  );

  // Inputs change and outputs are sampled on the falling edge.
  task automatic test_reset;
    rst_n = 1'b0; req = 4'b0; done = 1'b0;
    #2;
    checks++;
    if ({gnt, gnt_valid, gnt_idx, busy} !== 8'b0) begin
      errors++;
      $display("FAIL reset_state: got gnt=%b v=%b idx=%0d busy=%b, want all zero", gnt, gnt_valid, gnt_idx, busy);
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({gnt, gnt_valid, busy} !== 6'b0) begin
      errors++;
      $display("FAIL idle_after_reset: got gnt=%b v=%b busy=%b, want zero", gnt, gnt_valid, busy);
    end
  endtask

  task automatic test_round_robin;
    logic [3:0] exp_g [5];
    logic [1:0] exp_i [5];
    exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    exp_i = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    req = 4'b1111; done = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if ({gnt, gnt_idx, gnt_valid, busy} !== {exp_g[k], exp_i[k], 1'b1, 1'b1}) begin
        errors++;
        $display("FAIL rr_grant%0d: got gnt=%b idx=%0d v=%b busy=%b, want gnt=%b idx=%0d v=1 busy=1",
                 k, gnt, gnt_idx, gnt_valid, busy, exp_g[k], exp_i[k]);
      end
      done = 1'b1;
      if (k == 4) req = 4'b0;  // done together with owner drop: one release
      @(negedge clk);
      done = 1'b0;
      checks++;
      if ({gnt, gnt_valid, busy} !== 6'b0) begin
        errors++;
        $display("FAIL rr_bubble%0d: got gnt=%b v=%b busy=%b, want zero", k, gnt, gnt_valid, busy);
      end
    end
    @(negedge clk);
    checks++;
    if ({gnt, busy, gnt_idx} !== 7'b0) begin
      errors++;
      $display("FAIL rr_final_idle: got gnt=%b busy=%b idx=%0d, want 0000/0/0", gnt, busy, gnt_idx);
    end
  endtask

  // last_idx = 0 on entry
  task automatic test_single_hold;
    req = 4'b0100;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if ({gnt, gnt_idx, busy} !== {4'b0100, 2'd2, 1'b1}) begin
        errors++;
        $display("FAIL hold_c%0d: got gnt=%b idx=%0d busy=%b, want 0100/2/1", k, gnt, gnt_idx, busy);
      end
    end
    req = 4'b0000;
    @(negedge clk);
    checks++;
    if ({gnt, gnt_valid, busy, gnt_idx} !== {4'b0, 1'b0, 1'b0, 2'd2}) begin
      errors++;
      $display("FAIL hold_drop: got gnt=%b v=%b busy=%b idx=%0d, want 0000/0/0/2", gnt, gnt_valid, busy, gnt_idx);
    end
  endtask

  // last_idx = 2 on entry
  task automatic test_no_preempt;
    req = 4'b0100;
    @(negedge clk);
    checks++;
    if ({gnt, gnt_idx} !== {4'b0100, 2'd2}) begin
      errors++;
      $display("FAIL np_grant: got gnt=%b idx=%0d, want 0100/2", gnt, gnt_idx);
    end
    req = 4'b0101;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++;
      if (gnt !== 4'b0100) begin
        errors++;
        $display("FAIL np_held%0d: got gnt=%b, want 0100", k, gnt);
      end
    end
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    checks++;
    if ({gnt, busy} !== 5'b0) begin
      errors++;
      $display("FAIL np_release: got gnt=%b busy=%b, want 0000/0", gnt, busy);
    end
    @(negedge clk);
    checks++;
    if ({gnt, gnt_idx, busy} !== {4'b0001, 2'd0, 1'b1}) begin
      errors++;
      $display("FAIL np_wrap: got gnt=%b idx=%0d busy=%b, want 0001/0/1", gnt, gnt_idx, busy);
    end
    req = 4'b0;
    @(negedge clk);
  endtask

  // last_idx = 0 on entry; lone requester re-granted after its bubble
  task automatic test_back_to_back;
    req = 4'b0010;
    @(negedge clk);
    checks++;
    if ({gnt, gnt_idx} !== {4'b0010, 2'd1}) begin
      errors++;
      $display("FAIL b2b_first: got gnt=%b idx=%0d, want 0010/1", gnt, gnt_idx);
    end
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    checks++;
    if (gnt !== 4'b0) begin
      errors++;
      $display("FAIL b2b_bubble: got gnt=%b, want 0000", gnt);
    end
    @(negedge clk);
    checks++;
    if ({gnt, gnt_idx} !== {4'b0010, 2'd1}) begin
      errors++;
      $display("FAIL b2b_regrant: got gnt=%b idx=%0d, want 0010/1", gnt, gnt_idx);
    end
    req = 4'b0;
    @(negedge clk);
  endtask

  // last_idx = 1 on entry
  task automatic test_reset_mid_grant;
    req = 4'b1000;
    @(negedge clk);
    checks++;
    if ({gnt, gnt_idx} !== {4'b1000, 2'd3}) begin
      errors++;
      $display("FAIL rst_pre: got gnt=%b idx=%0d, want 1000/3", gnt, gnt_idx);
    end
    #2;
    req = 4'b1001;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({gnt, gnt_valid, busy, gnt_idx} !== 8'b0) begin
      errors++;
      $display("FAIL rst_async: got gnt=%b v=%b busy=%b idx=%0d, want all zero", gnt, gnt_valid, busy, gnt_idx);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({gnt, gnt_idx} !== {4'b0001, 2'd0}) begin
      errors++;
      $display("FAIL rst_first_grant: got gnt=%b idx=%0d, want 0001/0", gnt, gnt_idx);
    end
    req = 4'b0;
    @(negedge clk);
  endtask

  task automatic test_done_idle;
    done = 1'b1; req = 4'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++;
      if ({gnt, gnt_valid, busy, gnt_idx} !== 8'b0) begin
        errors++;
        $display("FAIL done_idle%0d: got gnt=%b v=%b busy=%b idx=%0d, want all zero", k, gnt, gnt_valid, busy, gnt_idx);
      end
    end
    done = 1'b0;
  endtask

  // Random traffic against a behavioural model plus per-cycle invariants.
  task automatic test_random;
    logic       m_busy;
    logic [1:0] m_idx, m_last, cand, enc;
    logic [3:0] m_gnt;
    logic       found;
    int         nerr_before;
    rst_n = 1'b0; req = 4'b0; done = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    m_busy = 1'b0; m_idx = 2'd0; m_last = 2'd3;
    nerr_before = errors;
    for (int c = 0; c < 10000; c++) begin
      @(negedge clk);
      enc   = gnt[3] ? 2'd3 : gnt[2] ? 2'd2 : gnt[1] ? 2'd1 : 2'd0;
      m_gnt = m_busy ? (4'b0001 << m_idx) : 4'b0000;
      checks++;
      if (!$onehot0(gnt)) begin
        errors++;
        $display("FAIL inv_onehot c%0d: got gnt=%b, want onehot0", c, gnt);
      end
      checks++;
      if (gnt_valid !== (|gnt)) begin
        errors++;
        $display("FAIL inv_valid c%0d: got v=%b, want %b", c, gnt_valid, |gnt);
      end
      if (gnt_valid) begin
        checks++;
        if (gnt !== (4'b0001 << gnt_idx) || enc !== gnt_idx) begin
          errors++;
          $display("FAIL inv_idx c%0d: got gnt=%b idx=%0d enc=%0d, want consistent", c, gnt, gnt_idx, enc);
        end
      end
      checks++;
      if ({gnt, gnt_idx, busy} !== {m_gnt, m_idx, m_busy}) begin
        errors++;
        $display("FAIL rand_model c%0d: got gnt=%b idx=%0d busy=%b, want gnt=%b idx=%0d busy=%b",
                 c, gnt, gnt_idx, busy, m_gnt, m_idx, m_busy);
      end
      if (errors - nerr_before > 20) begin
        $display("FAIL rand_abort: too many random errors, stopping random run");
        break;
      end
      req  = 4'($urandom_range(0, 15));
      done = ($urandom_range(0, 3) == 0);
      if (!m_busy) begin
        found = 1'b0;
        for (int k = 1; k <= 4; k++) begin
          cand = m_last + 2'(k);
          if (!found && req[cand]) begin
            found = 1'b1;
            m_idx = cand;
          end
        end
        m_busy = found;
      end else if (done || !req[m_idx]) begin
        m_busy = 1'b0;
        m_last = m_idx;
      end
    end
    req = 4'b0; done = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset;
    test_round_robin;
    test_single_hold;
    test_no_preempt;
    test_back_to_back;
    test_reset_mid_grant;
    test_done_idle;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rr_grant_arbiter.md
Name: rr_grant_arbiter

Overview:
- Four-requester round-robin arbiter; produces a registered one-hot grant vector.
- Sits directly upstream of the 4-to-2 one-hot encoder stage; its grant lines drive that encoder's y0..y3 inputs.
- Also emits its own binary grant index, so the bench can cross-check it against the encoder's d1:d0 outputs.
- Grant is held, i.e. locked to the winning requester, until the owner signals completion or drops its request.

Parameters:
- NREQ, 4, number of requesters. The RTL must support only 4; any other value triggers an elaboration-time error.
- IDX_W, 2, width of the binary grant index. Must equal log2(NREQ).

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset. Assertion clears state immediately; deassertion is synchronised externally.
- req  input  NREQ  request lines; bit i high means requester i wants the resource. Level-sensitive.
- done  input  1  the current grant owner finishes this cycle; sampled only in GRANT.
- gnt  output  NREQ  registered one-hot grant; all-zero when nothing is granted.
- gnt_valid  output  1  high exactly when gnt is non-zero.
- gnt_idx  output  IDX_W  binary index of the set gnt bit; holds the last value while gnt_valid=0.
- busy  output  1  high while the FSM is in GRANT.

Behaviour:
- Reset values (asynchronous, rst_n=0):
  - gnt=4'b0000, gnt_valid=0, gnt_idx=2'd0, busy=0.
  - FSM returns to IDLE.
  - last_idx=2'd3, so requester 0 has top priority after reset.
- FSM states: IDLE, GRANT. Encoding is 1 bit, defined in the package.
- IDLE:
  - If req==0, stay in IDLE with outputs at zero.
  - Otherwise, pick the winner by rotating priority: search starts at (last_idx+1) mod 4 and wraps upward.
  - On the next edge: gnt=onehot(winner), gnt_idx=winner, gnt_valid=1, busy=1, state moves to GRANT.
  - Latency is 1 cycle from req sampled to gnt visible.
- GRANT:
  - gnt, gnt_idx and gnt_valid are held stable. No preemption: other requests are ignored, even those with higher rotating priority.
  - Release condition: done=1, or req[gnt_idx]=0.
  - On the release edge: gnt=0, gnt_valid=0, busy=0, last_idx=gnt_idx, state moves to IDLE.
- Bubble rule: after every release there is exactly one cycle with gnt=0, even if other requests are pending. Re-arbitration happens in that IDLE cycle. Maximum grant rate is therefore one grant per 2 cycles.
- Simultaneous events:
  - done=1 together with changes on other req bits: release takes effect; the new req values are used in the following IDLE cycle.
  - done=1 together with a drop of the owner's req: a single release, no double effect.
- Fairness: a continuously asserted requester is granted within 3 other grants. No starvation.
- Wrap-around: after last_idx=3, the search starts at 0.
- Single requester: the same requester may be re-granted after the bubble cycle.
- Reset asserted mid-GRANT: outputs clear immediately, without waiting for a clock edge; last_idx returns to 3.
- Invariants, which the bench must assert:
  - gnt is always one-hot or zero, i.e. $onehot0.
  - gnt_valid == |gnt.
  - When gnt_valid=1, gnt == (1 << gnt_idx).
  - done is ignored in IDLE.

Decomposition:
- Package rr_arb_pkg holds:
  - the NREQ and IDX_W constants;
  - the state typedef {IDLE, GRANT};
  - a function rr_pick(req, last_idx) that returns the winner index.
- One natural sub-module: rr_priority_pick. It is purely combinational and rotates req by last_idx+1, applies a fixed priority, then rotates the result back.
- The FSM and registers live in rr_grant_arbiter itself.

Test Plan:
- Reset then req=4'b1111, done pulsed 1 cycle after each grant → grant sequence 0001, 0010, 0100, 1000, 0001, with gnt_idx 0, 1, 2, 3, 0 and one zero cycle between grants.
- req=4'b0100 only, hold 5 cycles, then drop req[2] → gnt=0100 and gnt_idx=2 from cycle 1 to the drop; gnt=0 on the edge after the drop; busy follows the same timing.
- While requester 2 is granted, raise req[0]; then done=1 → no preemption; after the bubble, gnt=0001 (search started at 3, req[3]=0, wraps to 0).
- rst_n driven low mid-GRANT between clock edges → gnt=0, gnt_valid=0, busy=0 immediately. After release with req=4'b1001, the first grant is 0001 (last_idx reset to 3).
- done pulsed in IDLE with req=0 → no state change, all outputs stay 0.
- Random req/done for 10k cycles → the invariants above hold every cycle. Feeding gnt into the downstream encoder gives d1:d0 == gnt_idx whenever gnt_valid=1.
